// File: rtl/idelay_fine_ctrl.sv
// IDELAY fine/coarse tap controller: stages per-channel taps through a
// shared coarse bus and applies all staged fine taps with one LD strobe.
module idelay_fine_ctrl #(
  parameter int NUM_CH        = 8,
  parameter int CH_BITS       = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_apply,
  input  logic [CH_BITS-1:0]    cmd_ch,
  input  logic [7:0]            cmd_dly,
  output logic [4:0]            dly_coarse,
  output logic [NUM_CH-1:0]     dly_ld,
  output logic                  dly_set,
  output logic [3*NUM_CH-1:0]   dly_fine,
  output logic [NUM_CH-1:0]     pending,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SET    = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  localparam logic [CH_BITS:0] CH_LIM = (CH_BITS+1)'(NUM_CH);
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  logic [1:0]          state;
  logic [3:0]          cnt;
  logic [3*NUM_CH-1:0] fine_stage;
  logic [NUM_CH-1:0]   ch_hot;
  logic                accept;
  logic                wr_ok;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign wr_ok     = ({1'b0, cmd_ch} < CH_LIM);

  always_comb begin
    ch_hot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cmd_ch == CH_BITS'(k)) ch_hot[k] = 1'b1;
    end
  end

  // dly_ld/dly_set are registered on the accepting edge so each strobe
  // occupies exactly the LOAD or SET cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dly_coarse <= '0;
      dly_ld     <= '0;
      dly_set    <= 1'b0;
      dly_fine   <= '0;
      pending    <= '0;
      fine_stage <= '0;
      err        <= 1'b0;
    end else begin
      dly_ld  <= '0;
      dly_set <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_apply) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (pending[k])
                  dly_fine[3*k +: 3] <= fine_stage[3*k +: 3];
              end
              pending <= '0;
              dly_set <= 1'b1;
              state   <= SET;
            end else if (wr_ok) begin
              dly_coarse <= cmd_dly[7:3];
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_hot[k])
                  fine_stage[3*k +: 3] <= cmd_dly[2:0];
              end
              dly_ld <= ch_hot;
              state  <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          pending <= pending | dly_ld;
          state   <= IDLE;
        end
        SET: begin
          if (SETTLE_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            cnt   <= SETTLE_LAST;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_fine_ctrl.sv
// Bench for idelay_fine_ctrl: two instances (settle 4 and 0) checked
// every cycle against a countdown-based behavioural model.
module tb_idelay_fine_ctrl;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_apply = 1'b0;
  logic [2:0] cmd_ch = '0;
  logic [7:0] cmd_dly = '0;

  logic ready_a, set_a, busy_a, err_a;
  logic [4:0] coarse_a;
  logic [N-1:0] ld_a, pend_a;
  logic [3*N-1:0] fine_a;

  logic ready_b, set_b, busy_b, err_b;
  logic [4:0] coarse_b;
  logic [N-1:0] ld_b, pend_b;
  logic [3*N-1:0] fine_b;

  idelay_fine_ctrl #(.NUM_CH(N), .CH_BITS(3), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_apply(cmd_apply), .cmd_ch(cmd_ch), .cmd_dly(cmd_dly),
    .dly_coarse(coarse_a), .dly_ld(ld_a), .dly_set(set_a),
    .dly_fine(fine_a), .pending(pend_a), .busy(busy_a), .err(err_a)
  );

  idelay_fine_ctrl #(.NUM_CH(N), .CH_BITS(3), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_apply(cmd_apply), .cmd_ch(cmd_ch), .cmd_dly(cmd_dly),
    .dly_coarse(coarse_b), .dly_ld(ld_b), .dly_set(set_b),
    .dly_fine(fine_b), .pending(pend_b), .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  int settle [2] = '{4, 0};
  int m_left [2];
  logic [31:0] m_ld [2];
  logic [31:0] m_pend [2];
  logic m_set [2];
  logic m_err [2];
  int m_coarse [2];
  int m_stage [2][N];
  int m_fine [2][N];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_ld[i] = 0; m_pend[i] = 0;
      m_set[i] = 1'b0; m_err[i] = 1'b0; m_coarse[i] = 0;
      for (int k = 0; k < N; k++) begin
        m_stage[i][k] = 0;
        m_fine[i][k] = 0;
      end
    end
  endfunction

  function automatic void mstep(input int i);
    if (m_left[i] == 0) begin
      if (cmd_valid) begin
        if (cmd_apply) begin
          for (int k = 0; k < N; k++)
            if (m_pend[i][k]) m_fine[i][k] = m_stage[i][k];
          m_pend[i] = 0;
          m_set[i] = 1'b1;
          m_left[i] = 1 + settle[i];
        end else if (int'(cmd_ch) < N) begin
          m_coarse[i] = int'(cmd_dly) / 8;
          m_stage[i][cmd_ch] = int'(cmd_dly) % 8;
          m_ld[i] = 32'd1 << cmd_ch;
          m_left[i] = 1;
        end else begin
          m_err[i] = 1'b1;
        end
      end
    end else begin
      m_pend[i] = m_pend[i] | m_ld[i];
      m_ld[i] = 0;
      m_set[i] = 1'b0;
      m_left[i] = m_left[i] - 1;
    end
  endfunction

  function automatic logic [31:0] pack_fine(input int i);
    logic [31:0] r = 0;
    for (int k = 0; k < N; k++) r = r | (32'(m_fine[i][k]) << (3 * k));
    return r;
  endfunction

  always @(posedge clk) if (rst) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge rst) mreset();

  task automatic cmp(input int i, input string t, input logic rdy,
                     input logic bsy, input logic [4:0] co,
                     input logic [N-1:0] ld, input logic st,
                     input logic [3*N-1:0] fi, input logic [N-1:0] pe,
                     input logic er);
    check({t, " cmd_ready"}, 32'(rdy), 32'(m_left[i] == 0));
    check({t, " busy"}, 32'(bsy), 32'(m_left[i] != 0));
    check({t, " dly_coarse"}, 32'(co), 32'(m_coarse[i]));
    check({t, " dly_ld"}, 32'(ld), m_ld[i]);
    check({t, " dly_set"}, 32'(st), 32'(m_set[i]));
    check({t, " dly_fine"}, 32'(fi), pack_fine(i));
    check({t, " pending"}, 32'(pe), m_pend[i]);
    check({t, " err"}, 32'(er), 32'(m_err[i]));
    check({t, " strobe overlap"}, 32'((ld != 0) && st), 32'd0);
    check({t, " ld onehot"}, 32'($countones(ld) <= 1), 32'd1);
  endtask

  always @(negedge clk) if (run) begin
    cmp(0, "A", ready_a, busy_a, coarse_a, ld_a, set_a, fine_a, pend_a, err_a);
    cmp(1, "B", ready_b, busy_b, coarse_b, ld_b, set_b, fine_b, pend_b, err_b);
  end

  int ld1_cnt = 0;
  int set_cnt = 0;
  always @(negedge clk) begin
    if (ld_a[1]) ld1_cnt++;
    if (set_a) set_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready_a && ready_b) && n < 100) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(ready_a && ready_b), 32'd1);
  endtask

  task automatic issue(input logic ap, input logic [2:0] ch,
                       input logic [7:0] d);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_apply = ap;
    cmd_ch = ch;
    cmd_dly = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, c0, sc, acc;
    logic ap, prev, a;
    logic [N-1:0] p;
    mreset();
    repeat (3) tick();
    check("reset ready", 32'(ready_a), 32'd1);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset fine", 32'(fine_a), 32'd0);
    run = 1'b1;
    rst = 1'b1;
    tick();

    issue(1'b0, 3'd2, 8'hAD);
    check("stage coarse", 32'(coarse_a), 32'd21);
    check("stage ld", 32'(ld_a), 32'h04);
    tick();
    check("stage ld off", 32'(ld_a), 32'h00);
    check("stage pending", 32'(pend_a), 32'h04);
    check("stage busy", 32'(busy_a), 32'd0);
    check("stage fine2", 32'(fine_a[8:6]), 32'd0);

    sc = set_cnt;
    issue(1'b0, 3'd5, 8'h13);
    issue(1'b1, 3'd0, 8'h00);
    check("apply set", 32'(set_a), 32'd1);
    check("apply fine2", 32'(fine_a[8:6]), 32'd5);
    check("apply fine5", 32'(fine_a[17:15]), 32'd3);
    check("apply pending", 32'(pend_a), 32'd0);
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      tick();
    end
    check("apply busy cycles", 32'(n), 32'd5);
    check("apply set count", 32'(set_cnt - sc), 32'd1);

    c0 = ld1_cnt;
    issue(1'b0, 3'd1, 8'h0F);
    issue(1'b0, 3'd1, 8'h0A);
    issue(1'b1, 3'd0, 8'h00);
    wait_idle();
    check("overwrite ld pulses", 32'(ld1_cnt - c0), 32'd2);
    check("overwrite fine1", 32'(fine_a[5:3]), 32'd2);

    issue(1'b0, 3'd3, 8'h22);
    wait_idle();
    p = pend_a;
    issue(1'b0, 3'd7, 8'hFF);
    check("err set", 32'(err_a), 32'd1);
    check("err no ld", 32'(ld_a), 32'd0);
    check("err busy", 32'(busy_a), 32'd0);
    check("err pending", 32'(pend_a), 32'(p));
    issue(1'b0, 3'd6, 8'h11);
    issue(1'b0, 3'd0, 8'h08);
    wait_idle();
    check("err sticky", 32'(err_a), 32'd1);

    sc = set_cnt;
    issue(1'b1, 3'd0, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst coarse", 32'(coarse_a), 32'd0);
    check("rst ld", 32'(ld_a), 32'd0);
    check("rst set", 32'(set_a), 32'd0);
    check("rst fine", 32'(fine_a), 32'd0);
    check("rst pending", 32'(pend_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst err", 32'(err_a), 32'd0);
    tick();
    rst = 1'b1;
    check("rst ready", 32'(ready_a), 32'd1);
    sc = set_cnt;
    repeat (10) tick();
    check("rst no set", 32'(set_cnt - sc), 32'd0);

    wait_idle();
    cmd_valid = 1'b1;
    ap = 1'b0;
    acc = 0;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cmd_apply = ap;
      cmd_ch = 3'($urandom_range(0, N - 1));
      cmd_dly = 8'($urandom);
      a = ready_b;
      tick();
      if (a) begin
        acc++;
        ap = ~ap;
        check("b2b spacing", 32'(prev), 32'd0);
      end
      prev = a;
    end
    cmd_valid = 1'b0;
    check("b2b accepts", 32'(acc), 32'd10);

    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_apply = ($urandom_range(0, 3) == 0);
      cmd_ch = 3'($urandom_range(0, 7));
      cmd_dly = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idelay_fine_ctrl.md
IDELAY_FINE_CTRL -- requirements
Module: idelay_fine_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of delay channels controlled, legal range 1..32.
REQ-002 SHALL have parameter CH_BITS, default 3: channel-index width, with NUM_CH <= 2**CH_BITS.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: idle cycles after each apply, legal range 0..15.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-007 SHALL have port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-008 SHALL have port cmd_apply, input, 1: 1 = apply all staged values; 0 = stage a write.
REQ-009 SHALL have port cmd_ch, input, CH_BITS: target channel for a write.
REQ-010 SHALL have port cmd_dly, input, 8: [7:3] is the coarse tap and [2:0] is the fine tap.
REQ-011 SHALL have port dly_coarse, output, 5: shared coarse-value bus to every channel's CNTVALUEIN.
REQ-012 SHALL have port dly_ld, output, NUM_CH: one-hot pipe-load strobe, driving LDPIPEEN of each channel.
REQ-013 SHALL have port dly_set, output, 1: common apply strobe, driving LD of all channels.
REQ-014 SHALL have port dly_fine, output, 3*NUM_CH: applied fine tap per channel, with channel k at bits [3k+2:3k].
REQ-015 SHALL have port pending, output, NUM_CH: channel staged but not yet applied.
REQ-016 SHALL have port busy, output, 1: the state is not IDLE.
REQ-017 SHALL have port err, output, 1: sticky flag for an out-of-range channel write.

Function
REQ-018 SHALL implement the states IDLE, LOAD, SET and SETTLE.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-020 SHALL, on an accepted write (cmd_apply=0) with cmd_ch<NUM_CH, register dly_coarse=cmd_dly[7:3], store cmd_dly[2:0] in fine_stage[cmd_ch], and enter LOAD.
REQ-021 SHALL, in LOAD, assert dly_ld[cmd_ch] for exactly one cycle while dly_coarse holds that value, set pending[cmd_ch], then return to IDLE; write throughput is one per 2 cycles.
REQ-022 SHALL hold dly_coarse at its last loaded value outside LOAD.
REQ-023 SHALL, on an accepted write with cmd_ch>=NUM_CH, set err, pulse no dly_ld, change no staging state, and remain in IDLE.
REQ-024 SHALL, on an accepted apply, enter SET.
REQ-025 SHALL, in SET, assert dly_set for exactly one cycle; in the same cycle dly_fine takes fine_stage for every channel whose pending bit is 1 (other channels unchanged) and pending clears to 0.
REQ-026 SHALL enter SETTLE after SET and count SETTLE_CYCLES cycles before IDLE; with SETTLE_CYCLES=0, SET goes directly to IDLE.
REQ-027 SHALL, on an apply with pending all zero, still pulse dly_set and run SETTLE.
REQ-028 SHALL, on repeated writes to the same channel before an apply, keep the last fine value and pulse dly_ld on every write.
REQ-029 SHALL never assert dly_ld and dly_set in the same cycle, and dly_ld SHALL be at most one-hot.
REQ-030 SHALL ignore cmd_* while cmd_ready=0 and never queue commands.

Reset
REQ-031 SHALL, while rst=0, force state IDLE and dly_coarse, dly_ld, dly_set, dly_fine, pending, fine_stage, err, busy and the settle counter to 0, with cmd_ready=1 after release.
REQ-032 SHALL abandon any operation on reset mid-LOAD, SET or SETTLE: no further strobes occur and no partial apply is retained.

Verification
REQ-033 SHALL verify staging: write ch2 with 0xAD -> next cycle dly_coarse=21 and dly_ld=0x04 for one cycle, then pending=0x04, busy=0, and dly_fine[8:6] still 0.
REQ-034 SHALL verify apply: write ch2 with 0xAD and ch5 with 0x13, then apply -> one dly_set cycle, dly_fine ch2=5 and ch5=3, pending=0, busy high for 1+4 cycles, cmd_ready back on cycle 6.
REQ-035 SHALL verify overwrite: write ch1 with 0x0F then ch1 with 0x0A, then apply -> two dly_ld[1] pulses and dly_fine ch1=2.
REQ-036 SHALL verify error: NUM_CH=6, write ch7 -> err=1, dly_ld stays 0, pending unchanged, and err stays 1 until reset.
REQ-037 SHALL verify reset mid-SETTLE: rst low for 1 cycle on the second SETTLE cycle -> all outputs 0 immediately, cmd_ready=1 after release, and no dly_set follows.
REQ-038 SHALL verify back-to-back traffic: cmd_valid held high with alternating write and apply commands and SETTLE_CYCLES=0 -> one command accepted every 2 cycles and no strobe overlap.
